protobuf_varint_decoder: RTL and testbench

PROTOBUF_VARINT_DECODER -- requirements
Module: protobuf_varint_decoder

---
 rtl/protobuf_varint_decoder.sv | 135 +++++++++++++
 tb/tb_protobuf_varint_decoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/protobuf_varint_decoder.sv
// Protobuf base-128 varint decoder: consumes a byte stream and produces one
// registered 64-bit result per varint, with optional zigzag (sint) decoding,
// overflow/over-length error detection and a saturating byte count.
module protobuf_varint_decoder #(
   parameter int unsigned MAX_BYTES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        zz_en,
   output logic [63:0] m_value,
   output logic [3:0]  m_len,
   output logic        m_error,
   output logic        m_valid,
   input  logic        m_ready
);

   localparam int unsigned VAL_W   = 64;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned SHIFT_W = 7;
   localparam int unsigned GROUP_W = 7;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      EMIT  = 2'd2
   } state_e;

   state_e             state_q;
   logic [VAL_W-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               zz_q;
   logic               s_ready_q;
   logic [VAL_W-1:0]   m_value_q;
   logic [CNT_W-1:0]   m_len_q;
   logic               m_error_q;
   logic               m_valid_q;

   logic               accept;
   logic               first;
   logic               last_slot;
   logic               cont;
   logic               ovf;
   logic [SHIFT_W-1:0] shamt;
   logic [VAL_W-1:0]   acc_d;
   logic [CNT_W-1:0]   cnt_d;
   logic               zz_d;
   logic [VAL_W-1:0]   dec_value;

   // Datapath for the byte being offered this cycle: merged accumulator,
   // saturating count, zigzag select and overflow detection.
   always_comb begin
      accept    = s_valid & s_ready_q;
      first     = (state_q == ACCUM) && (cnt_q == CNT_W'(0));
      last_slot = (cnt_q == CNT_W'(MAX_BYTES - 1));
      cont      = s_data[7];
      ovf       = last_slot && (s_data[6:1] != 6'd0);
      shamt     = SHIFT_W'(cnt_q) * SHIFT_W'(GROUP_W);
      acc_d     = (first ? VAL_W'(0) : acc_q) | (VAL_W'(s_data[6:0]) << shamt);
      cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
      zz_d      = first ? zz_en : zz_q;
      dec_value = zz_d ? ((acc_d >> 1) ^ (VAL_W'(0) - VAL_W'(acc_d[0]))) : acc_d;
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ACCUM;
         acc_q     <= '0;
         cnt_q     <= '0;
         zz_q      <= 1'b0;
         s_ready_q <= 1'b1;
         m_value_q <= '0;
         m_len_q   <= '0;
         m_error_q <= 1'b0;
         m_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (accept) begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_d;
                  zz_q  <= zz_d;
                  if (cont && last_slot) begin
                     state_q <= DRAIN;
                  end else if (!cont) begin
                     state_q   <= EMIT;
                     s_ready_q <= 1'b0;
                     m_valid_q <= 1'b1;
                     m_len_q   <= cnt_d;
                     m_error_q <= ovf;
                     m_value_q <= ovf ? VAL_W'(0) : dec_value;
                  end
               end
            end
            DRAIN: begin
               if (accept) begin
                  cnt_q <= cnt_d;
                  if (!cont) begin
                     state_q   <= EMIT;
                     s_ready_q <= 1'b0;
                     m_valid_q <= 1'b1;
                     m_len_q   <= cnt_d;
                     m_error_q <= 1'b1;
                     m_value_q <= '0;
                  end
               end
            end
            EMIT: begin
               if (m_ready) begin
                  state_q   <= ACCUM;
                  s_ready_q <= 1'b1;
                  m_valid_q <= 1'b0;
                  cnt_q     <= '0;
               end
            end
            default: begin
               state_q   <= ACCUM;
               s_ready_q <= 1'b1;
               m_valid_q <= 1'b0;
               cnt_q     <= '0;
            end
         endcase
      end
   end

   assign s_ready = s_ready_q;
   assign m_value = m_value_q;
   assign m_len   = m_len_q;
   assign m_error = m_error_q;
   assign m_valid = m_valid_q;

endmodule

// File: tb/tb_protobuf_varint_decoder.sv
// Self-checking bench for protobuf_varint_decoder: directed vector table,
// hand-written stall/reset sequences and randomized varints vs. a model.
module tb_protobuf_varint_decoder;

   typedef logic [7:0] byte_q_t[$];

   typedef struct {
      logic [127:0] bytes;
      int           n;
      bit           zz;
      logic [63:0]  val;
      logic [3:0]   len;
      bit           err;
   } vec_t;

   logic        clk;
   logic        reset;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic        zz_en;
   logic [63:0] m_value;
   logic [3:0]  m_len;
   logic        m_error;
   logic        m_valid;
   logic        m_ready;

   int tests = 0;
   int fails = 0;
   vec_t vecs[$];

   protobuf_varint_decoder #(.MAX_BYTES(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .s_data (s_data),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .zz_en  (zz_en),
      .m_value(m_value),
      .m_len  (m_len),
      .m_error(m_error),
      .m_valid(m_valid),
      .m_ready(m_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Offer one byte from a negedge; returns at the negedge after acceptance.
   task automatic send_byte(input logic [7:0] b, input logic zz);
      int n;
      s_data  = b;
      zz_en   = zz;
      s_valid = 1'b1;
      n = 0;
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         tests++;
         fails++;
         $display("FAIL send_timeout actual s_ready=%0b expected=1", s_ready);
         s_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   // Wait for a result, capture it and complete the handshake.
   task automatic get_result(output logic [63:0] v, output logic [3:0] l, output logic e);
      int n;
      n = 0;
      while (!m_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!m_valid) begin
         tests++;
         fails++;
         $display("FAIL result_timeout actual m_valid=%0b expected=1", m_valid);
         v = '0; l = '0; e = 1'b0;
         return;
      end
      v = m_value;
      l = m_len;
      e = m_error;
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
   endtask

   // zz_en is inverted after the first byte: it must have no effect there.
   task automatic run_varint(input byte_q_t q, input bit zz,
                             output logic [63:0] v, output logic [3:0] l, output logic e);
      foreach (q[i]) send_byte(q[i], (i == 0) ? zz : ~zz);
      get_result(v, l, e);
   endtask

   // Reference: arithmetic base-128 sum in a wide integer, range-checked.
   function automatic void model(input byte_q_t q, input bit zz,
                                 output logic [63:0] v, output logic [3:0] l, output logic e);
      logic [127:0] big;
      logic [63:0]  u;
      int n;
      n = q.size();
      big = '0;
      for (int i = 0; i < n && i < 10; i++)
         big = big + 128'(q[i][6:0]) * (128'(1) << (7 * i));
      e = (n > 10) || ((big >> 64) != 128'(0));
      l = (n > 15) ? 4'd15 : 4'(n);
      u = big[63:0];
      if (e)
         v = '0;
      else if (!zz)
         v = u;
      else if (u % 2 == 0)
         v = u / 2;
      else
         v = 64'(0) - (u / 2) - 64'(1);
   endfunction

   function automatic void add_vec(input logic [127:0] b, input int n, input bit zz,
                                   input logic [63:0] val, input logic [3:0] len, input bit err);
      vec_t t;
      t.bytes = b; t.n = n; t.zz = zz; t.val = val; t.len = len; t.err = err;
      vecs.push_back(t);
   endfunction

   initial begin
      logic [63:0] v, ev;
      logic [3:0]  l, el;
      logic        e, ee;
      byte_q_t     q;
      string       tag;

      // Bytes are listed first-byte-in-LSB.
      add_vec(128'h0a, 1, 0, 64'd10, 4'd1, 0);
      add_vec(128'h7f, 1, 0, 64'd127, 4'd1, 0);
      add_vec(128'h0180, 2, 0, 64'd128, 4'd2, 0);
      add_vec(128'h0af5d29f8a, 5, 0, 64'h00000000AEB48F8A, 4'd5, 0);
      add_vec(128'h0fffffffff, 5, 0, 64'h00000000FFFFFFFF, 4'd5, 0);
      add_vec(128'h01ffffffffffffffffff, 10, 0, 64'hFFFFFFFFFFFFFFFF, 4'd10, 0);
      add_vec(128'h03ffffffffffffffffff, 10, 0, 64'd0, 4'd10, 1);
      add_vec(128'h0580808080808080808080, 11, 0, 64'd0, 4'd11, 1);
      add_vec(128'h01, 1, 0, 64'd1, 4'd1, 0);
      add_vec(128'h03, 1, 1, 64'hFFFFFFFFFFFFFFFE, 4'd1, 0);
      add_vec(128'h04, 1, 1, 64'd2, 4'd1, 0);
      add_vec(128'h0196, 2, 1, 64'd75, 4'd2, 0);
      add_vec(128'h00808080808080808080808080808080, 16, 0, 64'd0, 4'd15, 1);

      reset = 1'b0; s_data = '0; s_valid = 1'b0; zz_en = 1'b0; m_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_s_ready", 64'(s_ready), 64'd1);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_error", 64'(m_error), 64'd0);
      check("rst_m_value", m_value, 64'd0);
      check("rst_m_len",   64'(m_len), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // Registered latency and stall: result held stable with m_ready low.
      send_byte(8'h03, 1'b1);
      check("lat_m_valid", 64'(m_valid), 64'd1);
      for (int c = 0; c < 5; c++) begin
         check("stall_m_valid", 64'(m_valid), 64'd1);
         check("stall_s_ready", 64'(s_ready), 64'd0);
         check("stall_m_value", m_value, 64'hFFFFFFFFFFFFFFFE);
         check("stall_m_len",   64'(m_len), 64'd1);
         check("stall_m_error", 64'(m_error), 64'd0);
         @(negedge clk);
      end
      get_result(v, l, e);
      check("post_hs_m_valid", 64'(m_valid), 64'd0);
      check("post_hs_s_ready", 64'(s_ready), 64'd1);

      // Directed table.
      foreach (vecs[k]) begin
         q.delete();
         for (int j = 0; j < vecs[k].n; j++) q.push_back(vecs[k].bytes[8*j +: 8]);
         run_varint(q, vecs[k].zz, v, l, e);
         tag = $sformatf("vec%0d", k);
         check({tag, "_value"}, v, vecs[k].val);
         check({tag, "_len"},   64'(l), 64'(vecs[k].len));
         check({tag, "_error"}, 64'(e), 64'(vecs[k].err));
      end

      // Reset mid-varint discards the partial result.
      send_byte(8'h80, 1'b0);
      send_byte(8'h80, 1'b0);
      reset = 1'b0;
      #1;
      check("midrst_s_ready", 64'(s_ready), 64'd1);
      check("midrst_m_valid", 64'(m_valid), 64'd0);
      check("midrst_m_error", 64'(m_error), 64'd0);
      check("midrst_m_value", m_value, 64'd0);
      check("midrst_m_len",   64'(m_len), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      q.delete(); q.push_back(8'h05);
      run_varint(q, 1'b0, v, l, e);
      check("midrst_next_value", v, 64'd5);
      check("midrst_next_len",   64'(l), 64'd1);
      check("midrst_next_error", 64'(e), 64'd0);

      // Reset while a result is pending drops it.
      send_byte(8'h07, 1'b0);
      reset = 1'b0;
      #1;
      check("emitrst_m_valid", 64'(m_valid), 64'd0);
      check("emitrst_s_ready", 64'(s_ready), 64'd1);
      check("emitrst_m_value", m_value, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Randomized varints against the model.
      for (int t = 0; t < 300; t++) begin
         int  n;
         int  mode;
         bit  zz;
         mode = int'($urandom_range(0, 3));
         case (mode)
            0:       n = int'($urandom_range(1, 3));
            1:       n = int'($urandom_range(4, 9));
            2:       n = 10;
            default: n = int'($urandom_range(11, 17));
         endcase
         zz = 1'($urandom_range(0, 1));
         q.delete();
         for (int j = 0; j < n - 1; j++) q.push_back(8'h80 | 8'($urandom_range(0, 127)));
         if (n == 10) q.push_back(8'($urandom_range(0, 3)));
         else         q.push_back(8'($urandom_range(0, 127)));
         model(q, zz, ev, el, ee);
         run_varint(q, zz, v, l, e);
         tag = $sformatf("rnd%0d", t);
         check({tag, "_value"}, v, ev);
         check({tag, "_len"},   64'(l), 64'(el));
         check({tag, "_error"}, 64'(e), 64'(ee));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
